// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg: command codes, unit indices, scheduler states and the
// command FIFO entry shared by the FPU command scheduler files.
package fpu_sched_pkg;

   // command encodings on i_cmd
   localparam logic [3:0] CMD_ADD  = 4'd1;
   localparam logic [3:0] CMD_SUB  = 4'd2;
   localparam logic [3:0] CMD_MUL  = 4'd3;
   localparam logic [3:0] CMD_COMP = 4'd4;
   localparam logic [3:0] CMD_DIV  = 4'd5;

   // bit positions in the o_start / i_unit_done vectors
   localparam int unsigned UNIT_ADD  = 0;
   localparam int unsigned UNIT_SUB  = 1;
   localparam int unsigned UNIT_MUL  = 2;
   localparam int unsigned UNIT_COMP = 3;
   localparam int unsigned UNIT_DIV  = 4;
   localparam int unsigned NUM_UNITS = 5;

   // slot positions inside i_res_flat (comparator has no data result)
   localparam int unsigned RES_SLOT_ADD = 0;
   localparam int unsigned RES_SLOT_SUB = 1;
   localparam int unsigned RES_SLOT_MUL = 2;
   localparam int unsigned RES_SLOT_DIV = 3;

   // FIFO entry fields are sized for the widest supported configuration
   localparam int unsigned MAX_DATA_W = 64;
   localparam int unsigned MAX_TAG_W  = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RUN,
      RESP
   } sched_state_t;

   typedef struct packed {
      logic [3:0]            cmd;
      logic [MAX_TAG_W-1:0]  tag;
      logic [MAX_DATA_W-1:0] a;
      logic [MAX_DATA_W-1:0] b;
   } sched_entry_t;

   function automatic logic cmd_legal(input logic [3:0] cmd);
      return (cmd >= CMD_ADD) && (cmd <= CMD_DIV);
   endfunction

   // one-hot unit select for a command; zero for illegal codes
   function automatic logic [NUM_UNITS-1:0] cmd_unit(input logic [3:0] cmd);
      logic [NUM_UNITS-1:0] oh;
      oh = '0;
      case (cmd)
         CMD_ADD:  oh[UNIT_ADD]  = 1'b1;
         CMD_SUB:  oh[UNIT_SUB]  = 1'b1;
         CMD_MUL:  oh[UNIT_MUL]  = 1'b1;
         CMD_COMP: oh[UNIT_COMP] = 1'b1;
         CMD_DIV:  oh[UNIT_DIV]  = 1'b1;
         default:  oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/fpu_sched_fifo.sv
// fpu_sched_fifo: synchronous FIFO, registered storage, no fall-through.
// A write into an empty FIFO becomes visible on rdata the following cycle.
module fpu_sched_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // pointers and occupancy; simultaneous push and pop keep count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // entry storage, not reset: only slots below count are ever read
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fpu_cmd_sched.sv
// fpu_cmd_sched: queues tagged FPU commands, issues one at a time to the
// add/sub/mul/comp/div units and returns tagged results in order.
// Optional build macro FPU_SCHED_DONE_HS_EN: completion is taken from the
// issued unit's i_unit_done strobe instead of the fixed latency counters.
module fpu_cmd_sched
   import fpu_sched_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned TAG_W      = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ADD_LAT    = 15,
   parameter int unsigned MUL_LAT    = 60,
   parameter int unsigned DIV_LAT    = 136
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [3:0]            i_cmd,
   input  logic [TAG_W-1:0]      i_tag,
   input  logic [DATA_W-1:0]     i_a,
   input  logic [DATA_W-1:0]     i_b,
   output logic [DATA_W-1:0]     o_op_a,
   output logic [DATA_W-1:0]     o_op_b,
   output logic [4:0]            o_start,
   input  logic [4*DATA_W-1:0]   i_res_flat,
   input  logic [2:0]            i_cmp_flags,
   input  logic [4:0]            i_unit_done,
   output logic                  o_res_valid,
   input  logic                  i_res_ready,
   output logic [DATA_W-1:0]     o_res,
   output logic [2:0]            o_res_flags,
   output logic [TAG_W-1:0]      o_res_tag,
   output logic                  o_res_err
);

   sched_state_t state;
   sched_state_t next_state;

   sched_entry_t entry_in;
   sched_entry_t head;
   logic         fifo_push;
   logic         fifo_pop;
   logic         fifo_full;
   logic         fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

   logic [3:0]        iss_cmd;
   logic [TAG_W-1:0]  iss_tag;
   logic [DATA_W-1:0] iss_a;
   logic [DATA_W-1:0] iss_b;

   logic [DATA_W-1:0] res_q;
   logic [2:0]        flags_q;
   logic [TAG_W-1:0]  tag_q;
   logic              err_q;

   logic [DATA_W-1:0] unit_result;
   logic              run_done;
   logic              unused_head_bits;

   assign entry_in.cmd = i_cmd;
   assign entry_in.tag = MAX_TAG_W'(i_tag);
   assign entry_in.a   = MAX_DATA_W'(i_a);
   assign entry_in.b   = MAX_DATA_W'(i_b);

   assign fifo_push = i_valid && !fifo_full;
   assign o_ready   = !fifo_full;

   fpu_sched_fifo #(
      .WIDTH ($bits(sched_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (entry_in),
      .pop   (fifo_pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count_unused)
   );

   // upper FIFO field bits beyond DATA_W/TAG_W are always zero
   assign unused_head_bits = ^{head.tag, head.a, head.b};

`ifdef FPU_SCHED_DONE_HS_EN
   logic unused_lat;
   assign unused_lat = ^{ADD_LAT, MUL_LAT, DIV_LAT};

   // only the strobe of the unit that was actually issued ends RUN
   assign run_done = |(i_unit_done & cmd_unit(iss_cmd));
`else
   localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT)
                                     ? ((MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT)
                                     : ((DIV_LAT > ADD_LAT) ? DIV_LAT : ADD_LAT);
   localparam int unsigned CNT_W = $clog2(MAX_LAT + 1);

   logic [CNT_W-1:0] cnt;
   logic             unused_done;

   assign unused_done = ^i_unit_done;

   // counter holds LAT-1 on entry to RUN so RUN lasts exactly LAT cycles
   function automatic logic [CNT_W-1:0] lat_load(input logic [3:0] cmd);
      logic [CNT_W-1:0] v;
      case (cmd)
         CMD_MUL: v = CNT_W'(MUL_LAT - 1);
         CMD_DIV: v = CNT_W'(DIV_LAT - 1);
         default: v = CNT_W'(ADD_LAT - 1);
      endcase
      return v;
   endfunction

   assign run_done = (cnt == '0);
`endif

   // select the issued unit's data result; comparator and illegal give 0
   always_comb begin
      unit_result = '0;
      case (iss_cmd)
         CMD_ADD: unit_result = i_res_flat[RES_SLOT_ADD*DATA_W +: DATA_W];
         CMD_SUB: unit_result = i_res_flat[RES_SLOT_SUB*DATA_W +: DATA_W];
         CMD_MUL: unit_result = i_res_flat[RES_SLOT_MUL*DATA_W +: DATA_W];
         CMD_DIV: unit_result = i_res_flat[RES_SLOT_DIV*DATA_W +: DATA_W];
         default: unit_result = '0;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // next state, FIFO pop, start pulse and result valid
   always_comb begin
      next_state  = state;
      fifo_pop    = 1'b0;
      o_start     = '0;
      o_res_valid = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            o_start    = cmd_unit(iss_cmd);
            next_state = cmd_legal(iss_cmd) ? RUN : RESP;
         end
         RUN: begin
            if (run_done) next_state = RESP;
         end
         RESP: begin
            o_res_valid = 1'b1;
            if (i_res_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // issue registers, latency counter and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_cmd <= '0;
         iss_tag <= '0;
         iss_a   <= '0;
         iss_b   <= '0;
         res_q   <= '0;
         flags_q <= '0;
         tag_q   <= '0;
         err_q   <= 1'b0;
`ifndef FPU_SCHED_DONE_HS_EN
         cnt     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  iss_cmd <= head.cmd;
                  iss_tag <= TAG_W'(head.tag);
                  iss_a   <= DATA_W'(head.a);
                  iss_b   <= DATA_W'(head.b);
               end
            end
            ISSUE: begin
               if (cmd_legal(iss_cmd)) begin
`ifndef FPU_SCHED_DONE_HS_EN
                  cnt <= lat_load(iss_cmd);
`endif
               end else begin
                  res_q   <= '0;
                  flags_q <= '0;
                  tag_q   <= iss_tag;
                  err_q   <= 1'b1;
               end
            end
            RUN: begin
               if (run_done) begin
                  res_q   <= unit_result;
                  flags_q <= (iss_cmd == CMD_COMP) ? i_cmp_flags : 3'b000;
                  tag_q   <= iss_tag;
                  err_q   <= 1'b0;
               end
`ifndef FPU_SCHED_DONE_HS_EN
               if (!run_done) cnt <= cnt - 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

   assign o_op_a      = (state == IDLE) ? '0 : iss_a;
   assign o_op_b      = (state == IDLE) ? '0 : iss_b;
   assign o_res       = res_q;
   assign o_res_flags = flags_q;
   assign o_res_tag   = tag_q;
   assign o_res_err   = err_q;

endmodule

// File: tb/tb_fpu_cmd_sched.sv
// tb_fpu_cmd_sched: directed checks of the FPU command scheduler with
// fixed unit results and hand-computed latencies (default parameters).
module tb_fpu_cmd_sched;

   localparam int unsigned DW = 32;
   localparam int unsigned TW = 4;

   localparam logic [31:0] ADD_R = 32'h4040_0000;
   localparam logic [31:0] SUB_R = 32'hBF80_0000;
   localparam logic [31:0] MUL_R = 32'h40C0_0000;
   localparam logic [31:0] DIV_R = 32'h3F00_0000;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            i_valid = 1'b0;
   logic            o_ready;
   logic [3:0]      i_cmd = '0;
   logic [TW-1:0]   i_tag = '0;
   logic [DW-1:0]   i_a = '0;
   logic [DW-1:0]   i_b = '0;
   logic [DW-1:0]   o_op_a;
   logic [DW-1:0]   o_op_b;
   logic [4:0]      o_start;
   logic [4*DW-1:0] i_res_flat = {DIV_R, MUL_R, SUB_R, ADD_R};
   logic [2:0]      i_cmp_flags = '0;
   logic [4:0]      i_unit_done = '0;
   logic            o_res_valid;
   logic            i_res_ready = 1'b0;
   logic [DW-1:0]   o_res;
   logic [2:0]      o_res_flags;
   logic [TW-1:0]   o_res_tag;
   logic            o_res_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fpu_cmd_sched #(
      .DATA_W     (DW),
      .TAG_W      (TW),
      .FIFO_DEPTH (4),
      .ADD_LAT    (15),
      .MUL_LAT    (60),
      .DIV_LAT    (136)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_cmd       (i_cmd),
      .i_tag       (i_tag),
      .i_a         (i_a),
      .i_b         (i_b),
      .o_op_a      (o_op_a),
      .o_op_b      (o_op_b),
      .o_start     (o_start),
      .i_res_flat  (i_res_flat),
      .i_cmp_flags (i_cmp_flags),
      .i_unit_done (i_unit_done),
      .o_res_valid (o_res_valid),
      .i_res_ready (i_res_ready),
      .o_res       (o_res),
      .o_res_flags (o_res_flags),
      .o_res_tag   (o_res_tag),
      .o_res_err   (o_res_err)
   );

   // one accepted command; returns 1 ns after the accepting edge
   task automatic push_cmd(input logic [3:0] c, input logic [TW-1:0] t,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
      int w;
      w = 0;
      while (!o_ready && w < 500) begin
         @(posedge clk); #1; w++;
      end
      if (!o_ready) begin
         checks++; errors++;
         $display("FAIL push_wait: o_ready=%b required 1 within 500 cycles", o_ready);
      end
      i_cmd = c; i_tag = t; i_a = a; i_b = b; i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   // edges until o_res_valid, plus start pulses seen on the way
   task automatic wait_valid(output int n, output int nstart, output logic [4:0] sor);
      n = 0; nstart = 0; sor = '0;
      while (!o_res_valid && n < 400) begin
         @(posedge clk); #1; n++;
         if (o_start !== 5'b0) begin
            nstart++;
            sor = sor | o_start;
         end
      end
   endtask

   task automatic accept_result();
      i_res_ready = 1'b1;
      @(posedge clk); #1;
      i_res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (o_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b required 1", o_ready);
      end
      checks++;
      if ({o_start, o_res_valid, o_res, o_res_flags, o_res_tag, o_res_err, o_op_a, o_op_b} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: start=%b valid=%b res=%h flags=%b tag=%h err=%b opa=%h required all 0",
                  o_start, o_res_valid, o_res, o_res_flags, o_res_tag, o_res_err, o_op_a);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      int n, ns;
      logic [4:0] sor;
      push_cmd(4'd1, 4'd3, 32'h3F80_0000, 32'h4000_0000);
      wait_valid(n, ns, sor);
      checks++;
      if (n != 17) begin errors++; $display("FAIL add_latency: got %0d required 17", n); end
      checks++;
      if (ns != 1 || sor !== 5'b00001) begin
         errors++; $display("FAIL add_start: pulses=%0d bits=%b required 1 and 00001", ns, sor);
      end
      checks++;
      if (o_res !== ADD_R || o_res_tag !== 4'd3 || o_res_err !== 1'b0 || o_res_flags !== 3'b000) begin
         errors++; $display("FAIL add_result: res=%h tag=%h err=%b flags=%b required 40400000 3 0 000",
                            o_res, o_res_tag, o_res_err, o_res_flags);
      end
      checks++;
      if (o_op_a !== 32'h3F80_0000 || o_op_b !== 32'h4000_0000) begin
         errors++; $display("FAIL add_operands: a=%h b=%h required 3f800000 40000000", o_op_a, o_op_b);
      end
      accept_result();
      checks++;
      if (o_res_valid !== 1'b0) begin errors++; $display("FAIL add_valid_drop: got %b required 0", o_res_valid); end
   endtask

   task automatic test_comp();
      int n, ns;
      logic [4:0] sor;
      i_cmp_flags = 3'b100;
      push_cmd(4'd4, 4'd5, 32'h4000_0000, 32'h3F80_0000);
      wait_valid(n, ns, sor);
      checks++;
      if (n != 17 || sor !== 5'b01000) begin
         errors++; $display("FAIL comp_timing: latency=%0d start=%b required 17 01000", n, sor);
      end
      checks++;
      if (o_res !== 32'h0 || o_res_flags !== 3'b100 || o_res_tag !== 4'd5 || o_res_err !== 1'b0) begin
         errors++; $display("FAIL comp_result: res=%h flags=%b tag=%h err=%b required 0 100 5 0",
                            o_res, o_res_flags, o_res_tag, o_res_err);
      end
      accept_result();
      i_cmp_flags = 3'b010;
      push_cmd(4'd1, 4'd6, 32'h3F80_0000, 32'h4000_0000);
      wait_valid(n, ns, sor);
      checks++;
      if (o_res_flags !== 3'b000 || o_res !== ADD_R || o_res_tag !== 4'd6) begin
         errors++; $display("FAIL comp_then_add: flags=%b res=%h tag=%h required 000 40400000 6",
                            o_res_flags, o_res, o_res_tag);
      end
      accept_result();
      i_cmp_flags = 3'b000;
   endtask

   task automatic test_illegal();
      int n, ns;
      logic [4:0] sor;
      push_cmd(4'd7, 4'd9, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_valid(n, ns, sor);
      checks++;
      if (n != 2 || ns != 0) begin
         errors++; $display("FAIL illegal_timing: latency=%0d starts=%0d required 2 0", n, ns);
      end
      checks++;
      if (o_res_err !== 1'b1 || o_res !== 32'h0 || o_res_tag !== 4'd9 || o_res_flags !== 3'b000) begin
         errors++; $display("FAIL illegal_result: err=%b res=%h tag=%h flags=%b required 1 0 9 000",
                            o_res_err, o_res, o_res_tag, o_res_flags);
      end
      accept_result();
   endtask

   task automatic test_back_to_back();
      logic [3:0]  cmds [5];
      logic [4:0]  starts [5];
      logic [31:0] ress [5];
      int start_k [5];
      int valid_k [5];
      int k, pushed, nst, nres;
      cmds    = '{4'd3, 4'd5, 4'd1, 4'd2, 4'd3};
      starts  = '{5'b00100, 5'b10000, 5'b00001, 5'b00010, 5'b00100};
      ress    = '{MUL_R, DIV_R, ADD_R, SUB_R, MUL_R};
      start_k = '{2, 65, 204, 222, 240};
      valid_k = '{63, 202, 220, 238, 301};
      i_res_ready = 1'b1;
      k = 0; pushed = 0; nst = 0; nres = 0;
      while (nres < 5 && k < 700) begin
         if (pushed < 5) begin
            checks++;
            if (o_ready !== 1'b1) begin
               errors++; $display("FAIL b2b_ready_push%0d: got %b required 1", pushed, o_ready);
            end
            i_cmd = cmds[pushed]; i_tag = TW'(10 + pushed);
            i_a = 32'h4000_0000; i_b = 32'h4040_0000; i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         @(posedge clk); #1; k++;
         if (i_valid) begin
            pushed++;
            if (pushed == 5) begin
               i_valid = 1'b0;
               checks++;
               if (o_ready !== 1'b0) begin
                  errors++; $display("FAIL b2b_full: o_ready=%b required 0 after 5th push", o_ready);
               end
            end
         end
         if (o_start !== 5'b0) begin
            checks++;
            if (nst >= 5 || o_start !== starts[nst] || k != start_k[nst]) begin
               errors++; $display("FAIL b2b_start%0d: start=%b at %0d required %b at %0d", nst, o_start, k,
                                  (nst < 5) ? starts[nst] : 5'b0, (nst < 5) ? start_k[nst] : 0);
            end
            nst++;
         end
         if (o_res_valid) begin
            checks++;
            if (k != valid_k[nres] || o_res_tag !== TW'(10 + nres) || o_res !== ress[nres]) begin
               errors++; $display("FAIL b2b_result%0d: at %0d tag=%h res=%h required at %0d tag=%h res=%h",
                                  nres, k, o_res_tag, o_res, valid_k[nres], TW'(10 + nres), ress[nres]);
            end
            nres++;
         end
      end
      @(posedge clk); #1;
      i_res_ready = 1'b0;
      checks++;
      if (nres != 5 || nst != 5) begin
         errors++; $display("FAIL b2b_count: results=%0d starts=%0d required 5 5", nres, nst);
      end
   endtask

   task automatic test_backpressure();
      int n, ns, bad;
      logic [4:0] sor;
      push_cmd(4'd1, 4'd4, 32'h3F80_0000, 32'h4000_0000);
      push_cmd(4'd2, 4'd5, 32'h3F80_0000, 32'h4000_0000);
      wait_valid(n, ns, sor);
      checks++;
      if (n != 16 || o_res_tag !== 4'd4 || o_res !== ADD_R) begin
         errors++; $display("FAIL bp_first: latency=%0d tag=%h res=%h required 16 4 40400000", n, o_res_tag, o_res);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (o_res_valid !== 1'b1 || o_res !== ADD_R || o_res_tag !== 4'd4 || o_start !== 5'b0
             || o_op_a !== 32'h3F80_0000) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL bp_hold: unstable cycles=%0d required 0", bad); end
      i_res_ready = 1'b1;
      @(posedge clk); #1;
      i_res_ready = 1'b0;
      checks++;
      if (o_res_valid !== 1'b0 || o_start !== 5'b0) begin
         errors++; $display("FAIL bp_release1: valid=%b start=%b required 0 00000", o_res_valid, o_start);
      end
      @(posedge clk); #1;
      checks++;
      if (o_start !== 5'b00010) begin errors++; $display("FAIL bp_release2: start=%b required 00010", o_start); end
      wait_valid(n, ns, sor);
      checks++;
      if (n != 16 || o_res_tag !== 4'd5 || o_res !== SUB_R) begin
         errors++; $display("FAIL bp_second: latency=%0d tag=%h res=%h required 16 5 bf800000", n, o_res_tag, o_res);
      end
      accept_result();
   endtask

   task automatic test_reset_mid_run();
      int n, ns, bad;
      logic [4:0] sor;
      push_cmd(4'd5, 4'd7, 32'h4000_0000, 32'h4080_0000);
      push_cmd(4'd1, 4'd8, 32'h3F80_0000, 32'h4000_0000);
      repeat (48) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({o_start, o_res_valid, o_res, o_res_flags, o_res_tag, o_res_err, o_op_a, o_op_b} !== '0) begin
         errors++; $display("FAIL rst_run_outputs: valid=%b res=%h tag=%h opa=%h required all 0",
                            o_res_valid, o_res, o_res_tag, o_op_a);
      end
      checks++;
      if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_run_ready: got %b required 1", o_ready); end
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (o_res_valid !== 1'b0 || o_start !== 5'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rst_run_quiet: active cycles=%0d required 0", bad); end
      push_cmd(4'd1, 4'd2, 32'h3F80_0000, 32'h4000_0000);
      wait_valid(n, ns, sor);
      checks++;
      if (n != 17 || o_res !== ADD_R || o_res_tag !== 4'd2 || sor !== 5'b00001) begin
         errors++; $display("FAIL rst_run_recover: latency=%0d res=%h tag=%h start=%b required 17 40400000 2 00001",
                            n, o_res, o_res_tag, sor);
      end
      accept_result();
   endtask

   initial begin
      test_reset();
      test_add();
      test_comp();
      test_illegal();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
